// File: rtl/io_input_bank.sv
// Memory-mapped bank of debounced input channels with sticky change flags
// and a clear-on-read status word; all state is clocked on io_clk.
module io_input_bank #(
    parameter int N_PORTS    = 2,
    parameter int WIDTH      = 5,
    parameter int DEBOUNCE   = 4,
    parameter int STATUS_IDX = 16
) (
    input  logic                       io_clk,
    input  logic                       resetn,
    input  logic [31:0]                addr,
    input  logic                       io_rd,
    input  logic [N_PORTS*WIDTH-1:0]   in_port,
    output logic [31:0]                io_read_data,
    output logic                       irq
);

    localparam logic [7:0] CNT_TC   = 8'(DEBOUNCE - 1);
    localparam logic [5:0] STAT_IDX = 6'(STATUS_IDX);

    logic [WIDTH-1:0]   s1_q     [N_PORTS];
    logic [WIDTH-1:0]   s1_d     [N_PORTS];
    logic [WIDTH-1:0]   s2_q     [N_PORTS];
    logic [WIDTH-1:0]   s2_d     [N_PORTS];
    logic [WIDTH-1:0]   s3_q     [N_PORTS];
    logic [WIDTH-1:0]   s3_d     [N_PORTS];
    logic [WIDTH-1:0]   stable_q [N_PORTS];
    logic [WIDTH-1:0]   stable_d [N_PORTS];
    logic [7:0]         cnt_q    [N_PORTS];
    logic [7:0]         cnt_d    [N_PORTS];
    logic [N_PORTS-1:0] flag_q;
    logic [N_PORTS-1:0] flag_d;
    logic [N_PORTS-1:0] accept;
    logic [5:0]         idx;
    logic               status_rd;
    logic               unused_addr;

    assign idx         = addr[7:2];
    assign status_rd   = io_rd && (idx == STAT_IDX);
    assign unused_addr = ^{addr[31:8], addr[1:0]};

    always_comb begin
        accept = '0;
        flag_d = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            s1_d[k]     = in_port[k*WIDTH +: WIDTH];
            s2_d[k]     = s1_q[k];
            s3_d[k]     = s2_q[k];
            stable_d[k] = stable_q[k];
            cnt_d[k]    = 8'd0;
            if (s2_q[k] == s3_q[k] && s2_q[k] != stable_q[k]) begin
                if (cnt_q[k] == CNT_TC) begin
                    accept[k]   = 1'b1;
                    stable_d[k] = s2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 8'd1;
                end
            end
            // A channel accepting on the clearing edge keeps its flag.
            flag_d[k] = accept[k] | (flag_q[k] & ~status_rd);
        end
    end

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < N_PORTS; k++) begin
                s1_q[k]     <= '0;
                s2_q[k]     <= '0;
                s3_q[k]     <= '0;
                stable_q[k] <= '0;
                cnt_q[k]    <= 8'd0;
            end
            flag_q <= '0;
        end else begin
            for (int k = 0; k < N_PORTS; k++) begin
                s1_q[k]     <= s1_d[k];
                s2_q[k]     <= s2_d[k];
                s3_q[k]     <= s3_d[k];
                stable_q[k] <= stable_d[k];
                cnt_q[k]    <= cnt_d[k];
            end
            flag_q <= flag_d;
        end
    end

    always_comb begin
        io_read_data = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (idx == 6'(k)) begin
                io_read_data[WIDTH-1:0] = stable_q[k];
            end
        end
        if (idx == STAT_IDX) begin
            io_read_data[N_PORTS-1:0] = flag_q;
        end
    end

    assign irq = |flag_q;

endmodule

// File: tb/tb_io_input_bank.sv
// Bench for io_input_bank: directed scenarios plus random traffic against a
// run-length model of the debounce rule, and a 3x32 decode/width instance.
module tb_io_input_bank;

    localparam int N    = 2;
    localparam int W    = 5;
    localparam int D    = 4;
    localparam int SIDX = 16;

    logic             io_clk = 1'b0;
    logic             resetn = 1'b0;
    logic [31:0]      addr   = '0;
    logic             io_rd  = 1'b0;
    logic [N*W-1:0]   in_port = '0;
    logic [31:0]      io_read_data;
    logic             irq;

    logic [31:0]      addr2   = '0;
    logic             io_rd2  = 1'b0;
    logic [95:0]      in_port2 = '0;
    logic [31:0]      io_read_data2;
    logic             irq2;

    int vectors     = 0;
    int miscompares = 0;

    // Model: per-channel history of sampled inputs and the run length of the
    // value currently seen two samples back.
    logic [W-1:0] m_p1      [N];
    logic [W-1:0] m_p2      [N];
    logic [W-1:0] m_run_val [N];
    int           m_run_len [N];
    logic [W-1:0] m_stable  [N];
    logic [N-1:0] m_flag;

    io_input_bank #(.N_PORTS(N), .WIDTH(W), .DEBOUNCE(D), .STATUS_IDX(SIDX)) dut (
        .io_clk(io_clk), .resetn(resetn), .addr(addr), .io_rd(io_rd),
        .in_port(in_port), .io_read_data(io_read_data), .irq(irq)
    );

    io_input_bank #(.N_PORTS(3), .WIDTH(32), .DEBOUNCE(4), .STATUS_IDX(16)) dut_wide (
        .io_clk(io_clk), .resetn(resetn), .addr(addr2), .io_rd(io_rd2),
        .in_port(in_port2), .io_read_data(io_read_data2), .irq(irq2)
    );

    always #5 io_clk = ~io_clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_p1[k] = '0; m_p2[k] = '0; m_run_val[k] = '0;
            m_run_len[k] = 1; m_stable[k] = '0;
        end
        m_flag = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int i;
        i = int'(a[7:2]);
        if (i < N) return 32'(m_stable[i]);
        if (i == SIDX) return 32'(m_flag);
        return 32'h0;
    endfunction

    task automatic model_edge(input logic [N*W-1:0] inp, input logic [31:0] a, input logic rd);
        logic         clr;
        logic [W-1:0] v;
        logic         acc;
        clr = rd && (int'(a[7:2]) == SIDX);
        for (int k = 0; k < N; k++) begin
            v = m_p2[k];
            m_p2[k] = m_p1[k];
            m_p1[k] = inp[k*W +: W];
            if (v == m_run_val[k]) m_run_len[k]++;
            else begin
                m_run_val[k] = v;
                m_run_len[k] = 1;
            end
            acc = (m_run_len[k] == D + 1) && (v != m_stable[k]);
            if (acc) m_stable[k] = v;
            m_flag[k] = acc ? 1'b1 : (clr ? 1'b0 : m_flag[k]);
        end
    endtask

    // One cycle: drive inputs after the falling edge, compare, then advance
    // the model past the coming rising edge.
    task automatic cycle(input logic rn, input logic [N*W-1:0] inp,
                         input logic [31:0] a, input logic rd);
        @(negedge io_clk);
        resetn = rn; in_port = inp; addr = a; io_rd = rd;
        #1;
        if (!rn) model_reset();
        chk("read_data", io_read_data, model_read(a));
        chk("irq", {31'b0, irq}, {31'b0, |m_flag});
        if (rn) model_edge(inp, a, rd);
    endtask

    function automatic logic [N*W-1:0] pk(input logic [W-1:0] c1, input logic [W-1:0] c0);
        return {c1, c0};
    endfunction

    task automatic chk_wide(input string name, input logic [31:0] a, input logic [31:0] exp);
        @(negedge io_clk);
        addr2 = a;
        #1;
        chk(name, io_read_data2, exp);
    endtask

    initial begin
        logic [N*W-1:0] cur;
        logic [31:0]    a;
        logic           rn;
        logic           rd;

        model_reset();

        // Reset with all inputs high
        cycle(1'b0, '1, 32'h0, 1'b0);  chk("rst_idx0", io_read_data, 32'h0);
        cycle(1'b0, '1, 32'h4, 1'b0);  chk("rst_idx1", io_read_data, 32'h0);
        cycle(1'b0, '1, 32'h40, 1'b0); chk("rst_status", io_read_data, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);

        // Input held through release: accepted at E6
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, '1, 32'h0, 1'b0);
            if (i == 6) chk("rel_before_e6", io_read_data, 32'h0);
        end
        cycle(1'b1, '1, 32'h0, 1'b0);  chk("rel_ch0", io_read_data, 32'h1F);
        cycle(1'b1, '1, 32'h40, 1'b0); chk("rel_status", io_read_data, 32'h3);
        chk("rel_irq", {31'b0, irq}, 32'h1);

        // Return channel 1 to 0, then clear
        repeat (8) cycle(1'b1, pk(5'h00, 5'h1F), 32'h4, 1'b0);
        cycle(1'b1, pk(5'h00, 5'h1F), 32'h40, 1'b1);
        cycle(1'b1, pk(5'h00, 5'h1F), 32'h40, 1'b0); chk("cleared", io_read_data, 32'h0);

        // Clean step on channel 1
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, pk(5'h0A, 5'h1F), 32'h4, 1'b0);
            if (i == 6) chk("step_pre", io_read_data, 32'h0);
            if (i == 7) chk("step_post", io_read_data, 32'h0000000A);
        end
        cycle(1'b1, pk(5'h0A, 5'h1F), 32'h40, 1'b0); chk("step_status", io_read_data, 32'h2);

        // Channel 0 back to 0, clear
        repeat (8) cycle(1'b1, pk(5'h0A, 5'h00), 32'h0, 1'b0);
        cycle(1'b1, pk(5'h0A, 5'h00), 32'h40, 1'b1);

        // Glitches of 3 and 4 cycles are rejected
        for (int l = 3; l <= 4; l++) begin
            repeat (l) cycle(1'b1, pk(5'h0A, 5'h1F), 32'h0, 1'b0);
            repeat (10) cycle(1'b1, pk(5'h0A, 5'h00), 32'h0, 1'b0);
            chk("glitch_stable", io_read_data, 32'h0);
            chk("glitch_irq", {31'b0, irq}, 32'h0);
        end
        // Five cycles is just long enough
        repeat (5) cycle(1'b1, pk(5'h0A, 5'h1F), 32'h0, 1'b0);
        repeat (10) cycle(1'b1, pk(5'h0A, 5'h00), 32'h0, 1'b0);
        cycle(1'b1, pk(5'h0A, 5'h00), 32'h40, 1'b1); chk("pulse5_flag", io_read_data, 32'h1);

        // Bounce, then hold 0x01
        for (int i = 0; i < 10; i++)
            cycle(1'b1, pk(5'h0A, (i % 2 == 0) ? 5'h01 : 5'h00), 32'h0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            cycle(1'b1, pk(5'h0A, 5'h01), 32'h0, 1'b0);
            if (j == 6) chk("bounce_pre", io_read_data, 32'h0);
            if (j == 7) chk("bounce_post", io_read_data, 32'h1);
        end
        cycle(1'b1, pk(5'h0A, 5'h01), 32'h40, 1'b0); chk("bounce_status", io_read_data, 32'h1);

        // Clear-on-read on the same edge channel 1 is accepted
        for (int i = 0; i < 6; i++) cycle(1'b1, pk(5'h15, 5'h01), 32'h0, 1'b0);
        cycle(1'b1, pk(5'h15, 5'h01), 32'h40, 1'b1); chk("cor_read1", io_read_data, 32'h1);
        cycle(1'b1, pk(5'h15, 5'h01), 32'h40, 1'b1); chk("cor_read2", io_read_data, 32'h2);
        cycle(1'b1, pk(5'h15, 5'h01), 32'h40, 1'b0); chk("cor_after", io_read_data, 32'h0);
        chk("cor_irq", {31'b0, irq}, 32'h0);

        // Reset mid-debounce aborts it
        repeat (3) cycle(1'b1, pk(5'h15, 5'h07), 32'h0, 1'b0);
        repeat (2) cycle(1'b0, pk(5'h00, 5'h00), 32'h0, 1'b0);
        repeat (10) cycle(1'b1, pk(5'h00, 5'h00), 32'h40, 1'b0);
        chk("abort_status", io_read_data, 32'h0);
        chk("abort_irq", {31'b0, irq}, 32'h0);

        // Random traffic
        cur = in_port;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, 5) == 0) cur[k*W +: W] = W'($urandom());
            a = $urandom();
            case ($urandom_range(0, 3))
                0: a[7:2] = 6'd0;
                1: a[7:2] = 6'd1;
                2: a[7:2] = 6'(SIDX);
                default: ;
            endcase
            rd = ($urandom_range(0, 3) == 0);
            rn = ($urandom_range(0, 299) != 0);
            cycle(rn, cur, a, rd);
        end

        // Wide instance: decode and full-width data
        in_port2 = {32'hDEADBEEF, 32'h12345678, 32'h0};
        repeat (9) cycle(1'b1, cur, 32'h0, 1'b0);
        chk_wide("wide_0x08", 32'h08, 32'hDEADBEEF);
        chk_wide("wide_0x0B", 32'h0B, 32'hDEADBEEF);
        chk_wide("wide_0x108", 32'h108, 32'hDEADBEEF);
        chk_wide("wide_0x0C", 32'h0C, 32'h0);
        chk_wide("wide_ch1", 32'h04, 32'h12345678);
        chk_wide("wide_status", 32'h40, 32'h6);
        chk("wide_irq", {31'b0, irq2}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
